// File: rtl/dragster_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dragster_pkg                                                         |
// | Frame geometry, register map and FSM encoding for the Dragster link. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dragster_pkg;

   localparam int DRAGSTER_FRAME_BITS = 16;
   localparam int DRAGSTER_ADDR_BITS  = 7;
   localparam int DRAGSTER_DATA_BITS  = 8;
   localparam int DRAGSTER_COUNT_BITS = 5;

   localparam logic [DRAGSTER_ADDR_BITS-1:0] DRAGSTER_REG_CTRL1    = 7'd1;
   localparam logic [DRAGSTER_ADDR_BITS-1:0] DRAGSTER_REG_CTRL2    = 7'd2;
   localparam logic [DRAGSTER_ADDR_BITS-1:0] DRAGSTER_REG_ADC_GAIN = 7'd3;
   localparam logic [DRAGSTER_ADDR_BITS-1:0] DRAGSTER_REG_CTRL3    = 7'd5;
   localparam logic [DRAGSTER_ADDR_BITS-1:0] DRAGSTER_REG_ADC_END  = 7'd9;

   typedef enum logic [2:0] {
      ST_WAIT_IDLE = 3'd0,
      ST_IDLE      = 3'd1,
      ST_ADDR      = 3'd2,
      ST_DATA      = 3'd3,
      ST_ERROR     = 3'd4
   } dragster_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_input_synchronizer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_input_synchronizer                                               |
// | Two-flop synchronizer plus a third stage for rise/fall detection.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_input_synchronizer (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [2:0] stage_q;
   logic [2:0] stage_d;

   always_comb begin
      stage_d = {stage_q[1:0], async_in};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign sync_out = stage_q[1];
   assign rise     = stage_q[1] & ~stage_q[2];
   assign fall     = ~stage_q[1] & stage_q[2];

endmodule
`default_nettype wire

// File: rtl/dragster_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dragster_spi_responder                                               |
// | Mode-0 SPI responder decoding 16-bit frames into a local reg file.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dragster_spi_responder
   import dragster_pkg::*;
#(
   parameter int                               SLAVE_INDEX         = 0,
   parameter int                               NUMBER_OF_REGISTERS = 16,
   parameter logic [DRAGSTER_ADDR_BITS-1:0]    UPDATE_ADDRESS      = DRAGSTER_REG_CTRL1
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               sclk,
   input  logic [1:0]                         ss_n,
   input  logic                               mosi,
   output logic                               miso,
   output logic                               miso_oe,
   output logic                               write_strobe,
   output logic [DRAGSTER_ADDR_BITS-1:0]      write_address,
   output logic [DRAGSTER_DATA_BITS-1:0]      write_data,
   output logic                               update_strobe,
   output logic                               address_error,
   output logic                               frame_error,
   input  logic [3:0]                         cfg_address,
   output logic [DRAGSTER_DATA_BITS-1:0]      cfg_data
);

   localparam int IDX_BITS = (NUMBER_OF_REGISTERS > 1) ? $clog2(NUMBER_OF_REGISTERS) : 1;
   localparam logic [DRAGSTER_COUNT_BITS-1:0] FRAME_COUNT =
      DRAGSTER_COUNT_BITS'(DRAGSTER_FRAME_BITS);
   localparam logic [DRAGSTER_COUNT_BITS-1:0] BYTE_COUNT =
      DRAGSTER_COUNT_BITS'(DRAGSTER_FRAME_BITS / 2);

   function automatic logic [IDX_BITS-1:0] to_index(input logic [DRAGSTER_ADDR_BITS-1:0] a);
      return IDX_BITS'(a);
   endfunction

   function automatic logic in_range(input logic [DRAGSTER_ADDR_BITS-1:0] a);
      return int'(a) < NUMBER_OF_REGISTERS;
   endfunction

   logic sclk_s, sclk_rise, sclk_fall;
   logic ss_s, ss_rise, ss_fall;
   logic mosi_s, mosi_unused_rise, mosi_unused_fall;
   logic unused_ss_bits;

   assign unused_ss_bits = ^{ss_n, sclk_s};

   spi_input_synchronizer u_sync_sclk (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (sclk),
      .sync_out (sclk_s),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   spi_input_synchronizer u_sync_ss (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (ss_n[SLAVE_INDEX]),
      .sync_out (ss_s),
      .rise     (ss_rise),
      .fall     (ss_fall)
   );

   spi_input_synchronizer u_sync_mosi (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (mosi),
      .sync_out (mosi_s),
      .rise     (mosi_unused_rise),
      .fall     (mosi_unused_fall)
   );

   dragster_state_e                   state_q, state_d;
   logic [DRAGSTER_COUNT_BITS-1:0]    bit_count_q, bit_count_d;
   logic [DRAGSTER_FRAME_BITS-1:0]    shift_in_q, shift_in_d;
   logic [DRAGSTER_DATA_BITS-1:0]     shift_out_q, shift_out_d;
   logic                              miso_oe_q, miso_oe_d;
   logic                              write_strobe_q, write_strobe_d;
   logic                              update_strobe_q, update_strobe_d;
   logic                              address_error_q, address_error_d;
   logic                              frame_error_q, frame_error_d;
   logic [DRAGSTER_ADDR_BITS-1:0]     write_address_q, write_address_d;
   logic [DRAGSTER_DATA_BITS-1:0]     write_data_q, write_data_d;
   logic [DRAGSTER_DATA_BITS-1:0]     regs_q [NUMBER_OF_REGISTERS];
   logic [DRAGSTER_DATA_BITS-1:0]     regs_d [NUMBER_OF_REGISTERS];

   logic                              frame_rd;
   logic [DRAGSTER_ADDR_BITS-1:0]     frame_addr;
   logic [DRAGSTER_DATA_BITS-1:0]     frame_data;
   logic [DRAGSTER_ADDR_BITS-1:0]     read_addr;
   logic [DRAGSTER_DATA_BITS-1:0]     read_data;

   // After 16 bits the address byte sits in the upper half; after 8 it is in the lower half.
   assign frame_rd   = shift_in_q[15];
   assign frame_addr = shift_in_q[14:8];
   assign frame_data = shift_in_q[7:0];
   assign read_addr  = shift_in_q[6:0];

   always_comb begin
      read_data = '0;
      if (in_range(read_addr)) begin
         read_data = regs_q[to_index(read_addr)];
      end
   end

   always_comb begin
      cfg_data = '0;
      if (in_range({3'b000, cfg_address})) begin
         cfg_data = regs_q[to_index({3'b000, cfg_address})];
      end
   end

   always_comb begin
      state_d         = state_q;
      bit_count_d     = bit_count_q;
      shift_in_d      = shift_in_q;
      shift_out_d     = shift_out_q;
      miso_oe_d       = miso_oe_q;
      write_strobe_d  = 1'b0;
      update_strobe_d = 1'b0;
      address_error_d = 1'b0;
      frame_error_d   = 1'b0;
      write_address_d = write_address_q;
      write_data_d    = write_data_q;
      regs_d          = regs_q;

      case (state_q)
         ST_WAIT_IDLE: begin
            miso_oe_d = 1'b0;
            if (ss_s) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            miso_oe_d = 1'b0;
            if (ss_fall) begin
               state_d     = ST_ADDR;
               bit_count_d = '0;
            end
         end
         ST_ADDR, ST_DATA, ST_ERROR: begin
            // Deselect takes priority over any sclk edge seen in the same cycle.
            if (ss_rise) begin
               state_d   = ST_IDLE;
               miso_oe_d = 1'b0;
               if (state_q != ST_ERROR && bit_count_q == FRAME_COUNT) begin
                  if (!frame_rd) begin
                     if (in_range(frame_addr)) begin
                        regs_d[to_index(frame_addr)] = frame_data;
                        write_strobe_d  = 1'b1;
                        write_address_d = frame_addr;
                        write_data_d    = frame_data;
                        update_strobe_d = (frame_addr == UPDATE_ADDRESS) && frame_data[7];
                     end else begin
                        address_error_d = 1'b1;
                     end
                  end
               end else begin
                  frame_error_d = 1'b1;
               end
            end else if (state_q != ST_ERROR) begin
               if (sclk_rise) begin
                  if (bit_count_q == FRAME_COUNT) begin
                     state_d = ST_ERROR;
                  end else begin
                     shift_in_d  = {shift_in_q[DRAGSTER_FRAME_BITS-2:0], mosi_s};
                     bit_count_d = bit_count_q + 1'b1;
                  end
               end else if (sclk_fall) begin
                  if (state_q == ST_ADDR && bit_count_q == BYTE_COUNT) begin
                     state_d = ST_DATA;
                     if (shift_in_q[7]) begin
                        shift_out_d = read_data;
                        miso_oe_d   = 1'b1;
                     end
                  end else if (state_q == ST_DATA && miso_oe_q) begin
                     if (bit_count_q == FRAME_COUNT) begin
                        miso_oe_d = 1'b0;
                     end else begin
                        shift_out_d = {shift_out_q[DRAGSTER_DATA_BITS-2:0], 1'b0};
                     end
                  end
               end
            end
         end
         default: begin
            state_d = ST_WAIT_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_WAIT_IDLE;
         bit_count_q     <= '0;
         shift_in_q      <= '0;
         shift_out_q     <= '0;
         miso_oe_q       <= 1'b0;
         write_strobe_q  <= 1'b0;
         update_strobe_q <= 1'b0;
         address_error_q <= 1'b0;
         frame_error_q   <= 1'b0;
         write_address_q <= '0;
         write_data_q    <= '0;
         for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q         <= state_d;
         bit_count_q     <= bit_count_d;
         shift_in_q      <= shift_in_d;
         shift_out_q     <= shift_out_d;
         miso_oe_q       <= miso_oe_d;
         write_strobe_q  <= write_strobe_d;
         update_strobe_q <= update_strobe_d;
         address_error_q <= address_error_d;
         frame_error_q   <= frame_error_d;
         write_address_q <= write_address_d;
         write_data_q    <= write_data_d;
         for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign miso_oe       = miso_oe_q & ~ss_s;
   assign miso          = miso_oe ? shift_out_q[DRAGSTER_DATA_BITS-1] : 1'b0;
   assign write_strobe  = write_strobe_q;
   assign update_strobe = update_strobe_q;
   assign address_error = address_error_q;
   assign frame_error   = frame_error_q;
   assign write_address = write_address_q;
   assign write_data    = write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dragster_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dragster_spi_responder                                            |
// | Directed and random SPI frames checked against a register-map model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dragster_spi_responder;

   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sclk;
   logic [1:0] ss_n;
   logic       mosi;
   logic       miso, miso_oe;
   logic       write_strobe, update_strobe, address_error, frame_error;
   logic [6:0] write_address;
   logic [7:0] write_data;
   logic [3:0] cfg_address;
   logic [7:0] cfg_data;

   int n_tests = 0;
   int n_fail  = 0;
   int ws_cnt = 0, us_cnt = 0, ae_cnt = 0, fe_cnt = 0, orphan_cnt = 0;
   logic [7:0] mem [16];

   dragster_spi_responder #(
      .SLAVE_INDEX         (0),
      .NUMBER_OF_REGISTERS (16),
      .UPDATE_ADDRESS      (7'd1)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .sclk          (sclk),
      .ss_n          (ss_n),
      .mosi          (mosi),
      .miso          (miso),
      .miso_oe       (miso_oe),
      .write_strobe  (write_strobe),
      .write_address (write_address),
      .write_data    (write_data),
      .update_strobe (update_strobe),
      .address_error (address_error),
      .frame_error   (frame_error),
      .cfg_address   (cfg_address),
      .cfg_data      (cfg_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (write_strobe)                   ws_cnt     <= ws_cnt + 1;
      if (update_strobe)                  us_cnt     <= us_cnt + 1;
      if (update_strobe && !write_strobe) orphan_cnt <= orphan_cnt + 1;
      if (address_error)                  ae_cnt     <= ae_cnt + 1;
      if (frame_error)                    fe_cnt     <= fe_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives one frame MSB-first and checks the outcome against the register-map model.
   task automatic run_frame(input logic [15:0] word, input int nbits, input int sel,
                            input int reset_at, input string tag);
      int ws0, us0, ae0, fe0, or0, oe_bad, lat, e_ws, e_us, e_ae, e_fe;
      logic rd, exp_oe;
      logic [6:0] addr;
      logic [7:0] data, rd_byte, e_rd;
      rd = word[15]; addr = word[14:8]; data = word[7:0];
      ws0 = ws_cnt; us0 = us_cnt; ae0 = ae_cnt; fe0 = fe_cnt; or0 = orphan_cnt;
      rd_byte = 8'h00; oe_bad = 0; lat = -1;
      @(negedge clk);
      ss_n[sel] = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == reset_at) begin
            reset_n = 1'b0;
            repeat (3) @(negedge clk);
            reset_n = 1'b1;
         end
         if (i < 16) begin
            int idx;
            idx  = 15 - i;
            mosi = word[idx];
         end else begin
            mosi = 1'($urandom);
         end
         repeat (HALF) @(negedge clk);
         exp_oe = (sel == 0) && rd && (i >= 8) && (i < 16) && (reset_at < 0);
         if (miso_oe !== exp_oe) oe_bad++;
         if (!exp_oe && miso !== 1'b0) oe_bad++;
         if (i >= 8 && i < 16) rd_byte = {rd_byte[6:0], miso};
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      ss_n[sel] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (lat < 0 && (write_strobe || address_error || frame_error)) lat = k;
      end

      e_ws = 0; e_us = 0; e_ae = 0; e_fe = 0; e_rd = 8'h00;
      if (reset_at >= 0) begin
         for (int r = 0; r < 16; r++) mem[r] = 8'h00;
      end else if (sel == 0) begin
         if (nbits != 16) e_fe = 1;
         else if (rd) e_rd = (addr < 7'd16) ? mem[addr[3:0]] : 8'h00;
         else if (addr < 7'd16) begin
            mem[addr[3:0]] = data;
            e_ws = 1;
            e_us = (addr == 7'd1 && data[7]) ? 1 : 0;
         end else e_ae = 1;
      end

      check_eq({tag, ".write_strobe"},  ws_cnt - ws0, e_ws);
      check_eq({tag, ".update_strobe"}, us_cnt - us0, e_us);
      check_eq({tag, ".address_error"}, ae_cnt - ae0, e_ae);
      check_eq({tag, ".frame_error"},   fe_cnt - fe0, e_fe);
      check_eq({tag, ".update_alone"},  orphan_cnt - or0, 0);
      check_eq({tag, ".miso_oe_window"}, oe_bad, 0);
      check_eq({tag, ".miso_oe_after"}, miso_oe, 1'b0);
      if (e_ws != 0) begin
         check_eq({tag, ".write_address"}, write_address, addr);
         check_eq({tag, ".write_data"},    write_data, data);
      end
      if (e_ws + e_ae + e_fe != 0)
         check_eq({tag, ".latency_3_4"}, (lat >= 3 && lat <= 4), 1);
      if (sel == 0 && rd && nbits == 16 && reset_at < 0)
         check_eq({tag, ".read_byte"}, rd_byte, e_rd);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_regs(input string tag);
      for (int r = 0; r < 16; r++) begin
         cfg_address = 4'(r);
         #1;
         check_eq($sformatf("%s.cfg_data[%0d]", tag, r), cfg_data, mem[r]);
      end
   endtask

   initial begin
      logic [15:0] w;
      int nb, sel;
      reset_n = 1'b0; ss_n = 2'b11; sclk = 1'b0; mosi = 1'b0; cfg_address = 4'd0;
      for (int r = 0; r < 16; r++) mem[r] = 8'h00;
      repeat (5) @(negedge clk);
      check_eq("reset.write_strobe",  write_strobe, 1'b0);
      check_eq("reset.update_strobe", update_strobe, 1'b0);
      check_eq("reset.address_error", address_error, 1'b0);
      check_eq("reset.frame_error",   frame_error, 1'b0);
      check_eq("reset.miso",          miso, 1'b0);
      check_eq("reset.miso_oe",       miso_oe, 1'b0);
      check_eq("reset.write_address", write_address, 7'd0);
      check_eq("reset.write_data",    write_data, 8'd0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check_regs("reset");

      run_frame(16'h0533, 16, 0, -1, "cfg0");
      run_frame(16'h0223, 16, 0, -1, "cfg1");
      run_frame(16'h033F, 16, 0, -1, "cfg2");
      run_frame(16'h091F, 16, 0, -1, "cfg3");
      run_frame(16'h01A1, 16, 0, -1, "cfg4");
      check_regs("cfgseq");

      run_frame(16'h0533, 16, 0, -1, "rd_wr");
      run_frame(16'h8500, 16, 0, -1, "rd5");
      run_frame(16'h0544, 11, 0, -1, "short11");
      run_frame(16'h0544, 16, 0, -1, "after_short");
      run_frame(16'h2055, 16, 0, -1, "oor_wr");
      run_frame(16'hA000, 16, 0, -1, "oor_rd");
      run_frame(16'h0577, 17, 0, -1, "long17");
      run_frame(16'h0533, 16, 0, 6, "midreset");
      run_frame(16'h0566, 16, 0, -1, "post_reset");
      run_frame(16'h0799, 16, 1, -1, "other_ss");
      run_frame(16'h8700, 16, 1, -1, "other_ss_rd");
      check_regs("directed");

      for (int t = 0; t < 40; t++) begin
         w = 16'($urandom);
         w[14:8] = 7'($urandom_range(0, 23));
         nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 19)) : 16;
         sel = ($urandom_range(0, 7) == 0) ? 1 : 0;
         run_frame(w, nb, sel, -1, $sformatf("rnd%0d", t));
      end
      check_regs("random");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
